led_marquee_monitor: RTL and testbench
======================================

Name: led_marquee_monitor

Overview:
- Receive-side checker for the 16-bit LED marquee bus driven by the button/switch LED block.
- Samples the LED bus on a strobe, decodes run length and head position, and locks onto the pattern.
- Counts legal one-position rotate-left steps and flags any illegal transition.
- Sits beside the LED driver, for the board self-test and for bench scoreboarding.

Parameters:
- W, 16, LED bus width; only 16 is supported.
- CNT_W, 8, width of the step counter; the counter saturates.

Ports:
- clk       input   1      system clock, rising edge
- rst_n     input   1      asynchronous active-low reset
- sample    input   1      capture led_in this cycle
- clr       input   1      synchronous clear of step_cnt and err
- led_in    input   16     observed LED bus
- locked    output  1      a valid run is being tracked
- err       output  1      sticky illegal-pattern/transition flag
- len       output  5      number of ones in the last sample, 0..16
- head      output  4      run head index of the last sample
- step_cnt  output  CNT_W  legal rotate-left steps seen, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; prev=0; locked=0; err=0; len=0; head=0; step_cnt=0. All outputs are registered.
- Valid pattern: nonzero, and the ones form exactly one circularly contiguous run. 0xFFFF is valid.
- head: the index i with led[i]=1 and led[(i+1) mod 16]=0. For 0xFFFF, head=15.
- rotl(x): {x[14:0],x[15]}.
- Latency: outputs reflect a sample on the clock edge that captures it (1 cycle). With sample=0, all state holds.
- On every sample: len, head and prev update from led_in, even for invalid patterns. For an invalid pattern, head=0.
- FSM states IDLE, LOCK, ERROR.
- IDLE + sample:
  - valid -> LOCK, locked=1.
  - invalid -> ERROR, err=1.
- LOCK + sample, checked in priority order:
  - led_in==prev: hold. No count; stay LOCK. This check precedes the rotate check, so 0xFFFF never counts.
  - led_in==rotl(prev): step_cnt+1, saturating at 2^CNT_W-1; stay LOCK.
  - otherwise: -> ERROR, locked=0, err=1, even if led_in is itself valid.
- ERROR + sample:
  - valid -> LOCK, locked=1; err stays set.
  - invalid -> stay ERROR.
- clr: zeroes step_cnt and err next cycle. The FSM state is unaffected.
  - clr and sample in the same cycle: clr wins for step_cnt and err. The FSM, len, head and prev still update.
  - A same-cycle illegal transition still moves the FSM to ERROR, but err reads 0.
- Reset asserted mid-operation: immediate return to reset values; no partial update.

Decomposition:
- Package led_marquee_pkg holds:
  - state enum {IDLE, LOCK, ERROR};
  - LED_W=16;
  - function rotl16.
- One combinational sub-module, led_run_analyze (led_in -> len, head, valid). It holds the popcount, the circular 1->0 edge count (==1, or all-ones) and the head encoder.

Test Plan:
- Reset, then sample 0x0000 -> state ERROR, err=1, locked=0, len=0, head=0, step_cnt=0.
- Reset, sample 0x0007, then 0x000E, then 0x000E -> after the first: locked=1, len=3, head=2. After the second: step_cnt=1, head=3. After the third: step_cnt stays 1.
- Wrap: lock on 0xC001, then sample 0x8003 -> step_cnt=1, len=3, head=1, locked=1, err=0.
- In LOCK on 0x0003, sample 0x0005 -> locked=0, err=1. Then sample 0x0001 -> locked=1, err=1. Then clr -> err=0.
- Lock on 0xFFFF, sample 0xFFFF ten times -> len=16, head=15, step_cnt=0, err=0.
- Lock on 0x0001, apply 300 successive rotl samples -> step_cnt=255. Assert rst_n=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_marquee_pkg.sv
// Shared types and helpers for the LED marquee receive-side monitor.
package led_marquee_pkg;

  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    ERROR = 2'd2
  } state_e;

  // One-position circular rotate left, bit 15 wraps into bit 0.
  function automatic logic [LED_W-1:0] rotl16(input logic [LED_W-1:0] x);
    return {x[LED_W-2:0], x[LED_W-1]};
  endfunction

endpackage

// File: rtl/led_run_analyze.sv
// Combinational decode of one LED sample: run length, run head, and whether
// the lit LEDs form a single circularly contiguous run.
module led_run_analyze
  import led_marquee_pkg::*;
(
  input  logic [LED_W-1:0] led_i,
  output logic [4:0]       len_o,
  output logic [3:0]       head_o,
  output logic             valid_o
);

  logic [4:0] edges;
  logic [3:0] fall_idx;
  logic       all_ones;

  // Popcount plus count of circular 1->0 edges; a single run has exactly one
  // such edge, except all-ones which has none but is still a legal run.
  always_comb begin
    len_o    = '0;
    edges    = '0;
    fall_idx = '0;
    for (int i = 0; i < LED_W; i++) begin
      len_o = len_o + 5'(led_i[i]);
      if (led_i[i] && !led_i[(i + 1) % LED_W]) begin
        edges    = edges + 5'd1;
        fall_idx = 4'(i);
      end
    end
    all_ones = &led_i;
    valid_o  = (edges == 5'd1) || all_ones;
    if (!valid_o)     head_o = '0;
    else if (all_ones) head_o = 4'(LED_W - 1);
    else              head_o = fall_idx;
  end

endmodule

// File: rtl/led_marquee_monitor.sv
// Receive-side checker for the 16-bit LED marquee bus: locks onto a single
// run, counts legal rotate-left steps, and flags illegal patterns/transitions.
module led_marquee_monitor
  import led_marquee_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             clr,
  input  logic [W-1:0]     led_in,
  output logic             locked,
  output logic             err,
  output logic [4:0]       len,
  output logic [3:0]       head,
  output logic [CNT_W-1:0] step_cnt
);

  state_e           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [4:0]       len_q, len_d;
  logic [3:0]       head_q, head_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [4:0] a_len;
  logic [3:0] a_head;
  logic       a_valid;

  led_run_analyze u_analyze (
    .led_i   (led_in),
    .len_o   (a_len),
    .head_o  (a_head),
    .valid_o (a_valid)
  );

  // Next-state: decode fields always follow a sample; FSM checks hold before
  // rotate so an all-ones bus never counts; clr overrides count and error.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    len_d   = len_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (sample) begin
      prev_d = led_in;
      len_d  = a_len;
      head_d = a_head;
      unique case (state_q)
        IDLE: begin
          if (a_valid) state_d = LOCK;
          else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        LOCK: begin
          if (led_in == prev_q) begin
            state_d = LOCK;
          end else if (led_in == rotl16(prev_q)) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        ERROR: begin
          if (a_valid) state_d = LOCK;
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      len_q   <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      len_q   <= len_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign locked   = (state_q == LOCK);
  assign err      = err_q;
  assign len      = len_q;
  assign head     = head_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_led_marquee_monitor.sv
// Scoreboard bench for led_marquee_monitor: a behavioural model pushes the
// expected outputs for every driven cycle; they are popped after the edge.
module tb_led_marquee_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] led_in = '0;
  logic        locked, err;
  logic [4:0]  len;
  logic [3:0]  head;
  logic [7:0]  step_cnt;

  led_marquee_monitor #(.W(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .clr      (clr),
    .led_in   (led_in),
    .locked   (locked),
    .err      (err),
    .len      (len),
    .head     (head),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [4:0] len;
    logic [3:0] head;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // model state: 0 idle, 1 lock, 2 error
  int          m_st;
  logic [15:0] m_prev;
  int          m_cnt;
  logic        m_err;
  int          m_len;
  int          m_head;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_rotl(input logic [15:0] x);
    return 16'(({16'h0, x} << 1) | ({16'h0, x} >> 15));
  endfunction

  function automatic logic [15:0] m_rotr(input logic [15:0] x, input int r);
    logic [31:0] d;
    d = {x, x} >> r;
    return d[15:0];
  endfunction

  function automatic int m_pop(input logic [15:0] x);
    int c = 0;
    for (int i = 0; i < 16; i++) if (x[i]) c++;
    return c;
  endfunction

  // Valid iff some right-rotation turns the word into a low-aligned block of
  // ones; the run then starts at that rotation amount.
  task automatic m_decode(input logic [15:0] x, output logic v, output int hd);
    int n;
    logic [16:0] blk;
    n   = m_pop(x);
    blk = (17'd1 << n) - 17'd1;
    v   = 1'b0;
    hd  = 0;
    if (n != 0) begin
      for (int r = 0; r < 16; r++) begin
        if (!v && m_rotr(x, r) == blk[15:0]) begin
          v  = 1'b1;
          hd = (r + n - 1) % 16;
        end
      end
    end
  endtask

  task automatic do_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b0; sample = 1'b0; clr = 1'b0; led_in = '0;
    m_st = 0; m_prev = '0; m_cnt = 0; m_err = 1'b0; m_len = 0; m_head = 0;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_len",    32'(len), 0);
    chk("rst_head",   32'(head), 0);
    chk("rst_cnt",    32'(step_cnt), 0);
    rst_n = 1'b1;
  endtask

  // Drive one cycle, advance the model, push expectation, then check it.
  task automatic step(input logic s, input logic c, input logic [15:0] x);
    logic v;
    int   hd;
    exp_t e, g;
    @(negedge clk);
    sample = s; clr = c; led_in = x;
    if (s) begin
      m_decode(x, v, hd);
      m_len  = m_pop(x);
      m_head = hd;
      case (m_st)
        0: if (v) m_st = 1; else begin m_st = 2; m_err = 1'b1; end
        1: if (x == m_prev) m_st = 1;
           else if (x == m_rotl(m_prev)) begin if (m_cnt < 255) m_cnt++; end
           else begin m_st = 2; m_err = 1'b1; end
        default: if (v) m_st = 1;
      endcase
      m_prev = x;
    end
    if (c) begin m_cnt = 0; m_err = 1'b0; end
    e.locked = (m_st == 1); e.err = m_err; e.len = 5'(m_len);
    e.head = 4'(m_head); e.cnt = 8'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    sample = 1'b0; clr = 1'b0;
    g = sb_q.pop_front();
    chk("locked", 32'(locked), 32'(g.locked));
    chk("err",    32'(err),    32'(g.err));
    chk("len",    32'(len),    32'(g.len));
    chk("head",   32'(head),   32'(g.head));
    chk("cnt",    32'(step_cnt), 32'(g.cnt));
  endtask

  initial begin
    logic [15:0] x;
    do_reset();

    // all-dark bus is illegal from IDLE
    step(1, 0, 16'h0000);
    chk("t1_err", 32'(err), 1);
    chk("t1_locked", 32'(locked), 0);

    // lock, one legal step, then a hold
    do_reset();
    step(1, 0, 16'h0007);
    chk("t2_head0", 32'(head), 2);
    step(1, 0, 16'h000E);
    chk("t2_cnt1", 32'(step_cnt), 1);
    step(1, 0, 16'h000E);
    chk("t2_hold", 32'(step_cnt), 1);

    // run wrapping across bit 15 -> bit 0
    do_reset();
    step(1, 0, 16'hC001);
    step(1, 0, 16'h8003);
    chk("t3_head", 32'(head), 1);
    chk("t3_cnt", 32'(step_cnt), 1);

    // illegal transition, relock, clear
    do_reset();
    step(1, 0, 16'h0003);
    step(1, 0, 16'h0005);
    step(1, 0, 16'h0001);
    chk("t4_err_sticky", 32'(err), 1);
    step(0, 1, 16'h0000);
    chk("t4_clr", 32'(err), 0);

    // all-ones never counts
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 0, 16'hFFFF);
    chk("t5_head", 32'(head), 15);
    chk("t5_cnt", 32'(step_cnt), 0);

    // clr coincident with an illegal transition: FSM moves, err reads 0
    do_reset();
    step(1, 0, 16'h0030);
    step(1, 0, 16'h0060);
    step(1, 1, 16'h0F0F);
    chk("t6_err", 32'(err), 0);
    chk("t6_locked", 32'(locked), 0);

    // randomized mix against the model
    do_reset();
    x = 16'h0003;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: x = m_rotl(x);
        2:    x = x;
        3:    x = m_rotl(16'(($urandom_range(1, 16) == 16) ? 16'hFFFF
                             : (16'(1) << $urandom_range(1, 15)) - 16'd1));
        default: x = 16'($urandom);
      endcase
      step($urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0, x);
    end

    // saturation, then async reset mid-run
    do_reset();
    x = 16'h0001;
    step(1, 0, x);
    for (int i = 0; i < 300; i++) begin
      x = m_rotl(x);
      step(1, 0, x);
    end
    chk("t7_sat", 32'(step_cnt), 255);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_arst_locked", 32'(locked), 0);
    chk("t7_arst_cnt", 32'(step_cnt), 0);
    chk("t7_arst_len", 32'(len), 0);
    chk("t7_arst_head", 32'(head), 0);
    chk("t7_arst_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
